fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Controller for the rv32i fetch stage. It owns the program counter and issues in-order requests to instruction memory, keeping at most `MAX_OUTSTANDING` requests in flight. Returned words go into a small buffer and are presented to decode with a valid/ready handshake. On a redirect from execute (branch, jump or trap) it flushes the buffer and discards stale in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `MAX_OUTSTANDING`, 2: maximum granted requests awaiting response (1..3).
- `BUF_DEPTH`, 2: instruction buffer entries (2..4); `MAX_OUTSTANDING` ≤ `BUF_DEPTH`.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `redirect_i`  in  1  one-cycle pulse: restart fetch at `redirect_pc_i`.
- `redirect_pc_i`  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- `imem_req_o`  out  1  request valid.
- `imem_addr_o`  out  32  request word address (byte address, [1:0]=0).
- `imem_gnt_i`  in  1  request accepted when `imem_req_o & imem_gnt_i`.
- `imem_rvalid_i`  in  1  response valid; responses return in request order.
- `imem_rdata_i`  in  32  response instruction word.
- `instr_valid_o`  out  1  buffer head valid.
- `instr_ready_i`  in  1  decode accepts the head when `instr_valid_o & instr_ready_i`.
- `instruction_o`  out  32  head instruction; 32'h0000_0013 (NOP) when the buffer is empty.
- `pc_o`  out  32  PC of the head instruction; equals `resp_pc` when the buffer is empty.

## Operation
- **State registers:**
  - `fetch_pc`: next request address.
  - `resp_pc`: PC of the next accepted response.
  - `pending`: 0..`MAX_OUTSTANDING`.
  - `discard`: 0..`MAX_OUTSTANDING`.
  - FIFO of {pc, instr} with `count`: 0..`BUF_DEPTH`.
- **Reset values:**
  - `fetch_pc` = `resp_pc` = `RESET_PC`; `pending` = `discard` = `count` = 0.
  - Outputs: `imem_req_o`=0, `imem_addr_o`=`RESET_PC`, `instr_valid_o`=0, `instruction_o`=NOP, `pc_o`=`RESET_PC`.
- **Pop:** `pop` = `instr_valid_o & instr_ready_i`.
- **Request condition:** `imem_req_o` = `!redirect_i & (pending < MAX_OUTSTANDING) & (pending + count - pop < BUF_DEPTH)`.
  - This is a credit scheme; the buffer can never overflow.
  - `instr_ready_i` reaches `imem_req_o` combinationally, by design.
- **Address:** `imem_addr_o` = `fetch_pc` always. The memory interface permits request withdrawal before grant.
- **Grant:** `fetch_pc` += 4 (mod 2^32, wraps 0xFFFF_FFFC→0); `pending`++.
- **Response with `discard`>0:** word dropped; `discard`--; `pending`--.
- **Response with `discard`=0:** push {`resp_pc`, `imem_rdata_i`}; `resp_pc` += 4; `pending`--.
- **Grant and response in the same cycle:** `pending` is unchanged.
- **Push and pop in the same cycle:** `count` is unchanged. A full buffer with a pop must still accept the push.
- **Redirect (highest priority):**
  - `fetch_pc` and `resp_pc` ← `{redirect_pc_i[31:2], 2'b00}`.
  - FIFO flushed (`count`←0); a pop in that cycle still completes.
  - `discard` ← `pending` − (`imem_rvalid_i` ? 1 : 0). Any response arriving that cycle is dropped.
  - `pending` ← `discard` value.
  - No request is issued that cycle.
- **Redirect during an active discard:** the new `discard` is computed from the current `pending`, so it covers every stale in-flight response.
- **Error conditions (assertion failures):**
  - `imem_rvalid_i` with `pending`=0.
  - `redirect_i` asserted two consecutive cycles. Each pulse must be applied fully, not merged.

## Timing
- Reset is asynchronous. `imem_req_o` may first assert in the first cycle with `rst_ni` high.
- Memory returns the response ≥1 cycle after grant.
- With a 1-cycle response and `instr_ready_i` held high, the block sustains one instruction per cycle. The first `instr_valid_o` comes 2 cycles after the first grant:
  - grant at cycle N;
  - rvalid at N+1, registered into the FIFO;
  - head visible at N+2.
- **Redirect penalty:** the request at the redirect target is issued the cycle after `redirect_i`. With 1-cycle memory, the first target instruction is valid 3 cycles after `redirect_i`.
- Buffer outputs come directly from the FIFO head registers; there is no combinational path from `imem_rdata_i` to `instruction_o`.
- `instr_valid_o` and `pc_o` stay stable while `instr_ready_i`=0.

## Test plan
- **Reset stream:** reset, 1-cycle memory with gnt=1 and ready=1.
  - Expect addresses 0x0, 0x4, 0x8… on consecutive cycles.
  - Expect `pc_o`/`instruction_o` to match the memory image, one per cycle from cycle 3.
- **Backpressure:** hold `instr_ready_i`=0 for 10 cycles.
  - `count` + `pending` never exceeds 2.
  - `imem_req_o` drops.
  - Head stays at the same PC; on release, no instruction is lost or duplicated.
- **Redirect with responses in flight:** `redirect_i` with target 0x100 while `pending`=2.
  - Both stale responses are dropped.
  - Next delivered `pc_o` = 0x100.
  - `instr_valid_o` is low until then.
- **Redirect coinciding with response and pop:** redirect in the same cycle as rvalid and pop, `redirect_pc_i`=0x203.
  - Response dropped; pop completes.
  - Fetch resumes at 0x200.
- **Random grant/latency:** random gnt stalls and 1–4 cycle latency with random ready, ≥1000 instructions.
  - Scoreboard confirms in-order, gap-free PCs.
- **Wrap:** redirect to 0xFFFF_FFF8.
  - Delivered PCs are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rv32i fetch-stage controller: owns the PC, issues in-order instruction memory
// requests under a credit limit, buffers returned words and hands them to decode.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned BUF_DEPTH       = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o
);

  localparam int unsigned PTR_W   = (BUF_DEPTH > 2) ? 2 : 1;
  localparam logic [1:0]  MAX_OUT = 2'(MAX_OUTSTANDING);
  localparam logic [3:0]  DEPTH   = 4'(BUF_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [1:0]       pending_q, pending_d;
  logic [1:0]       discard_q, discard_d;
  logic [2:0]       count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      buf_pc_q  [BUF_DEPTH];
  logic [31:0]      buf_ins_q [BUF_DEPTH];

  logic        pop, req, grant, push, drop;
  logic [3:0]  credit_used;
  logic [31:0] target_pc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign target_pc   = redirect_pc_i & 32'hFFFF_FFFC;
  assign pop         = instr_valid_o & instr_ready_i;
  // Credits count both buffered words and words still in flight, so a granted
  // request always has a buffer slot waiting for its response.
  assign credit_used = 4'(pending_q) + 4'(count_q) - {3'b000, pop};
  assign req         = rst_ni & ~redirect_i & (pending_q < MAX_OUT) & (credit_used < DEPTH);
  assign grant       = req & imem_gnt_i;
  assign drop        = imem_rvalid_i & (discard_q != 2'd0);
  assign push        = imem_rvalid_i & (discard_q == 2'd0) & ~redirect_i;

  assign imem_req_o    = req;
  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = (count_q != 3'd0);
  assign instruction_o = instr_valid_o ? buf_ins_q[rd_ptr_q] : NOP;
  assign pc_o          = instr_valid_o ? buf_pc_q[rd_ptr_q]  : resp_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    pending_d  = pending_q;
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect_i) begin
      // Everything still in flight becomes stale, except a response landing now,
      // which is dropped on the spot.
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      pending_d  = pending_q - {1'b0, imem_rvalid_i};
      discard_d  = pending_d;
      count_d    = 3'd0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      pending_d = pending_q + {1'b0, grant} - {1'b0, imem_rvalid_i};
      if (drop) discard_d = discard_q - 2'd1;
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      pending_q  <= 2'd0;
      discard_q  <= 2'd0;
      count_q    <= 3'd0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      pending_q  <= pending_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_pc_q[wr_ptr_q]  <= resp_pc_q;
      buf_ins_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

  a_rvalid_has_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_rvalid_i |-> (pending_q != 2'd0));
  a_redirect_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
    redirect_i |=> !redirect_i);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an in-order memory model and a PC scoreboard.
module tb_fetch_sequencer;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, redirect, gnt, rvalid, ready;
  logic [31:0] redirect_pc, rdata;
  logic        req_o, vld_o;
  logic [31:0] addr_o, ins_o, pc_o;

  fetch_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(req_o), .imem_addr_o(addr_o), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .instr_valid_o(vld_o), .instr_ready_i(ready),
    .instruction_o(ins_o), .pc_o(pc_o)
  );

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int lat    = 1;
  int grants = 0;
  int pops   = 0;
  bit rand_gnt = 1'b0;
  bit rand_lat = 1'b0;
  bit rst_next = 1'b0;
  bit bp_phase = 1'b0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] popped[$];
  logic [31:0] exp_pc = 32'h0;
  logic        s_req, s_vld;
  logic [31:0] s_addr, s_pc, s_ins;
  logic [31:0] wexp [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

  function automatic logic [31:0] img(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, update memory model and scoreboard.
  task automatic cycle(input bit redir, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst_n       = rst_next;
    redirect    = redir;
    redirect_pc = rpc;
    ready       = rdy;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      rvalid = 1'b1;
      rdata  = img(mq_addr[0]);
    end else begin
      rvalid = 1'b0;
      rdata  = 32'hBAD0_BAD0;
    end
    gnt = rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    s_req = req_o; s_vld = vld_o; s_addr = addr_o; s_pc = pc_o; s_ins = ins_o;
    if (rvalid) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (s_req && gnt) begin
      mq_addr.push_back(s_addr);
      mq_due.push_back(cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat));
      grants++;
    end
    if (s_vld && rdy) begin
      check("sb_pc", s_pc, exp_pc);
      check("sb_ins", s_ins, img(exp_pc));
      popped.push_back(s_pc);
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (redir) exp_pc = rpc & 32'hFFFF_FFFC;
    if (bp_phase) check("bp_credit_le2", 32'((grants - pops) <= 2), 32'd1);
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    int  n;
    bit  prev, rd;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; gnt = 1'b0;
    rvalid = 1'b0; rdata = '0; ready = 1'b0;

    cycle(0, 0, 1);
    cycle(0, 0, 1);
    check("rst_req", s_req, 0);
    check("rst_addr", s_addr, 32'h0);
    check("rst_vld", s_vld, 0);
    check("rst_ins", s_ins, NOP);
    check("rst_pc", s_pc, 32'h0);

    rst_next = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cycle(0, 0, 1);
      check("rs_req", s_req, 1);
      check("rs_addr", s_addr, 32'(4 * c));
      check("rs_vld", s_vld, 32'(c >= 2));
      if (c >= 2) check("rs_pc", s_pc, 32'(4 * (c - 2)));
    end

    bp_phase = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cycle(0, 0, 0);
      check("bp_req", s_req, 0);
      check("bp_vld", s_vld, 1);
      check("bp_pc", s_pc, 32'd24);
      check("bp_addr", s_addr, 32'd32);
    end
    for (int c = 0; c < 4; c++) begin
      cycle(0, 0, 1);
      check("rel_pc", s_pc, 32'(24 + 4 * c));
    end
    bp_phase = 1'b0;

    cycle(1, 32'h0000_0203, 1);
    check("rc_vld", s_vld, 1);
    check("rc_pop_pc", s_pc, 32'd40);
    check("rc_req", s_req, 0);
    lat = 3;
    cycle(0, 0, 1);
    check("rc_req0", s_req, 1);
    check("rc_addr0", s_addr, 32'h200);
    check("rc_vld0", s_vld, 0);
    check("rc_pc_empty", s_pc, 32'h200);
    cycle(0, 0, 1);
    check("rc_req1", s_req, 1);
    check("rc_addr1", s_addr, 32'h204);

    lat = 1;
    cycle(1, 32'h0000_0100, 1);
    check("rd_req", s_req, 0);
    cycle(0, 0, 1);
    check("rd_req_full", s_req, 0);
    check("rd_vld0", s_vld, 0);
    check("rd_pc_empty", s_pc, 32'h100);
    cycle(0, 0, 1);
    check("rd_req_tgt", s_req, 1);
    check("rd_addr_tgt", s_addr, 32'h100);
    check("rd_vld1", s_vld, 0);
    cycle(0, 0, 1);
    check("rd_vld2", s_vld, 0);
    cycle(0, 0, 1);
    check("rd_vld3", s_vld, 1);
    check("rd_pc3", s_pc, 32'h100);
    check("rd_ins3", s_ins, img(32'h100));

    cycle(1, 32'hFFFF_FFF8, 1);
    popped.delete();
    for (int c = 0; c < 20 && popped.size() < 3; c++) cycle(0, 0, 1);
    check("wrap_n", 32'(popped.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check("wrap_pc", (i < popped.size()) ? popped[i] : 32'hFFFF_FFFF, wexp[i]);

    rand_gnt = 1'b1;
    rand_lat = 1'b1;
    pops = 0;
    n    = 0;
    prev = 1'b0;
    while (pops < 1000 && n < 20000) begin
      rd = !prev && ($urandom_range(0, 63) == 0);
      cycle(rd, $urandom, 1'($urandom_range(0, 1)));
      prev = rd;
      n++;
    end
    check("rand_done", 32'(pops >= 1000), 32'd1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
